// File: rtl/uart_rx_cfg_if.sv
// Receive-side bundle for uart_rx_cfg: serial line, FIFO pop/clear controls and head-entry status.
// The module drives the outputs; the consumer drives the line and the controls.
interface uart_rx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 i_RX;
    logic                 i_READ;
    logic                 i_CLR_OVR;
    logic                 o_READY;
    logic [DATA_BITS-1:0] o_DATA;
    logic                 o_PARITY_ERR;
    logic                 o_FRAME_ERR;
    logic                 o_OVERRUN;

    modport slave (
        input  i_RX, i_READ, i_CLR_OVR,
        output o_READY, o_DATA, o_PARITY_ERR, o_FRAME_ERR, o_OVERRUN
    );

    modport master (
        output i_RX, i_READ, i_CLR_OVR,
        input  o_READY, o_DATA, o_PARITY_ERR, o_FRAME_ERR, o_OVERRUN
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop line synchronizer, mid-bit sampling FSM and a
// first-word-fall-through receive FIFO carrying {data, parity_err, frame_err} per frame.
module uart_rx_cfg #(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    uart_rx_cfg_if.slave  bus
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W        = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta_q, rx_sync_q;

    logic                 bit_done_c;
    logic                 push_c;
    logic                 perr_c;
    logic                 ferr_c;
    logic [ENT_W-1:0]     entry_c;

    logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
    logic                 ovr_q;
    logic                 empty_c, full_c, pop_c, wr_en_c, ovr_set_c;
    logic [ENT_W-1:0]     head_c;

    // Line synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.i_RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bit_done_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        push_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                par_d  = 1'b0;
                ferr_d = 1'b0;
                if (!rx_sync_q) begin
                    state_d = S_START;
                end
            end

            // Re-check the start bit half a bit in; a high line here is a glitch.
            S_START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_done_c) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PARITY: begin
                if (bit_done_c) begin
                    cnt_d   = '0;
                    par_d   = rx_sync_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Last stop sample pushes the frame; a low line there means a break is in progress.
            S_STOP: begin
                if (bit_done_c) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rx_sync_q;
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        push_c  = 1'b1;
                        idx_d   = '0;
                        state_d = rx_sync_q ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        perr_c = 1'b0;
        if (PARITY == 1) begin
            perr_c = ~(^shift_q ^ par_q);
        end else if (PARITY == 2) begin
            perr_c = ^shift_q ^ par_q;
        end
    end

    assign ferr_c  = ferr_q | ~rx_sync_q;
    assign entry_c = {shift_q, perr_c, ferr_c};

    // FIFO bookkeeping: the extra pointer MSB separates full from empty.
    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign full_c    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_c     = bus.i_READ && !empty_c;
    assign wr_en_c   = push_c && (!full_c || pop_c);
    assign ovr_set_c = push_c && full_c && !pop_c;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= entry_c;
                wr_ptr_q                   <= wr_ptr_q + 1'b1;
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // A new overrun wins over a clear in the same cycle.
            if (ovr_set_c) begin
                ovr_q <= 1'b1;
            end else if (bus.i_CLR_OVR) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign head_c           = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.o_READY      = !empty_c;
    assign bus.o_DATA       = head_c[ENT_W-1:2];
    assign bus.o_PARITY_ERR = head_c[1];
    assign bus.o_FRAME_ERR  = head_c[0];
    assign bus.o_OVERRUN    = ovr_q;

endmodule
